// File: rtl/mem_arbiter_pkg.sv
// Shared memory-bus definitions for the cache/memory arbiter: bus commands,
// tag width and the owner encoding kept in the outstanding-load table.
package mem_arbiter_pkg;

    localparam int TAG_W = 4;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'd0,
        BUS_LOAD  = 2'd1,
        BUS_STORE = 2'd2
    } bus_command_t;

    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } mem_owner_t;

endpackage

// File: rtl/mem_tag_owner_table.sv
// Records which cache owns each outstanding load tag. One allocation write
// port and one lookup/clear port; allocation beats clear on the same tag.
module mem_tag_owner_table
    import mem_arbiter_pkg::*;
#(
    parameter int NUM_TAGS = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             alloc_en,
    input  logic [TAG_W-1:0] alloc_tag,
    input  logic             alloc_owner,
    input  logic [TAG_W-1:0] ret_tag,
    output logic             ret_valid,
    output logic             ret_owner
);

    logic [NUM_TAGS-1:0] valid_q;
    logic [NUM_TAGS-1:0] owner_q;
    logic                alloc_in_range;
    logic                ret_in_range;

    assign alloc_in_range = (int'(alloc_tag) < NUM_TAGS);
    assign ret_in_range   = (ret_tag != '0) && (int'(ret_tag) < NUM_TAGS);

    always_comb begin
        ret_valid = 1'b0;
        ret_owner = 1'b0;
        if (ret_in_range) begin
            ret_valid = valid_q[ret_tag];
            ret_owner = owner_q[ret_tag];
        end
    end

    // The allocation write is placed after the clear so it takes precedence.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= '0;
            owner_q <= '0;
        end else begin
            if (ret_in_range) begin
                valid_q[ret_tag] <= 1'b0;
            end
            if (alloc_en && alloc_in_range) begin
                valid_q[alloc_tag] <= 1'b1;
                owner_q[alloc_tag] <= alloc_owner;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Merges icache and dcache memory ports onto one memory bus with dcache
// priority, an icache anti-starvation counter, and tag-based return routing.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int NUM_TAGS     = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       proc2Imem_command,
    input  logic [63:0]      proc2Imem_addr,
    input  logic [1:0]       proc2Dmem_command,
    input  logic [63:0]      proc2Dmem_addr,
    input  logic [63:0]      proc2Dmem_data,
    input  logic [TAG_W-1:0] mem2proc_response,
    input  logic [63:0]      mem2proc_data,
    input  logic [TAG_W-1:0] mem2proc_tag,
    output logic [1:0]       proc2mem_command,
    output logic [63:0]      proc2mem_addr,
    output logic [63:0]      proc2mem_data,
    output logic [TAG_W-1:0] Imem2proc_response,
    output logic [TAG_W-1:0] Dmem2proc_response,
    output logic [63:0]      Imem2proc_data,
    output logic [63:0]      Dmem2proc_data,
    output logic [TAG_W-1:0] Imem2proc_tag,
    output logic [TAG_W-1:0] Dmem2proc_tag,
    output logic             arb_err
);

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    logic       i_req;
    logic       d_req;
    logic       grant_i;
    logic       grant_d;
    logic [3:0] starve_cnt;
    logic       alloc_en;
    logic       ret_valid;
    logic       ret_owner;
    logic       ret_hit;
    logic       arb_err_q;

    assign i_req = (proc2Imem_command != BUS_NONE);
    assign d_req = (proc2Dmem_command != BUS_NONE);

    // dcache normally wins; a starved icache takes one cycle back.
    assign grant_d = d_req && !(i_req && (starve_cnt == STARVE_MAX));
    assign grant_i = i_req && !grant_d;

    always_comb begin
        proc2mem_command = BUS_NONE;
        proc2mem_addr    = '0;
        proc2mem_data    = '0;
        if (grant_d) begin
            proc2mem_command = proc2Dmem_command;
            proc2mem_addr    = proc2Dmem_addr;
            proc2mem_data    = proc2Dmem_data;
        end else if (grant_i) begin
            proc2mem_command = proc2Imem_command;
            proc2mem_addr    = proc2Imem_addr;
        end
    end

    assign Imem2proc_response = grant_i ? mem2proc_response : '0;
    assign Dmem2proc_response = grant_d ? mem2proc_response : '0;

    assign alloc_en = (grant_i || grant_d) && (proc2mem_command == BUS_LOAD)
                      && (mem2proc_response != '0);

    mem_tag_owner_table #(
        .NUM_TAGS (NUM_TAGS)
    ) u_owner_table (
        .clock       (clock),
        .reset       (reset),
        .alloc_en    (alloc_en),
        .alloc_tag   (mem2proc_response),
        .alloc_owner (grant_d ? OWNER_D : OWNER_I),
        .ret_tag     (mem2proc_tag),
        .ret_valid   (ret_valid),
        .ret_owner   (ret_owner)
    );

    assign ret_hit = (mem2proc_tag != '0) && ret_valid;

    assign Imem2proc_tag  = (ret_hit && ret_owner == OWNER_I) ? mem2proc_tag  : '0;
    assign Imem2proc_data = (ret_hit && ret_owner == OWNER_I) ? mem2proc_data : '0;
    assign Dmem2proc_tag  = (ret_hit && ret_owner == OWNER_D) ? mem2proc_tag  : '0;
    assign Dmem2proc_data = (ret_hit && ret_owner == OWNER_D) ? mem2proc_data : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            starve_cnt <= '0;
            arb_err_q  <= 1'b0;
        end else begin
            if (i_req && !grant_i) begin
                if (starve_cnt != STARVE_MAX) begin
                    starve_cnt <= starve_cnt + 4'd1;
                end
            end else begin
                starve_cnt <= '0;
            end
            if ((mem2proc_tag != '0) && !ret_valid) begin
                arb_err_q <= 1'b1;
            end
        end
    end

    assign arb_err = arb_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed test of mem_arbiter: grant priority, starvation relief, tag
// routing, same-cycle return/reallocation, stray tags and mid-run reset.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic        clock;
    logic        reset;
    logic [1:0]  proc2Imem_command;
    logic [63:0] proc2Imem_addr;
    logic [1:0]  proc2Dmem_command;
    logic [63:0] proc2Dmem_addr;
    logic [63:0] proc2Dmem_data;
    logic [3:0]  mem2proc_response;
    logic [63:0] mem2proc_data;
    logic [3:0]  mem2proc_tag;
    logic [1:0]  proc2mem_command;
    logic [63:0] proc2mem_addr;
    logic [63:0] proc2mem_data;
    logic [3:0]  Imem2proc_response;
    logic [3:0]  Dmem2proc_response;
    logic [63:0] Imem2proc_data;
    logic [63:0] Dmem2proc_data;
    logic [3:0]  Imem2proc_tag;
    logic [3:0]  Dmem2proc_tag;
    logic        arb_err;

    int n_checks = 0;
    int n_fail   = 0;

    mem_arbiter #(.STARVE_LIMIT(4), .NUM_TAGS(16)) dut (
        .clock              (clock),
        .reset              (reset),
        .proc2Imem_command  (proc2Imem_command),
        .proc2Imem_addr     (proc2Imem_addr),
        .proc2Dmem_command  (proc2Dmem_command),
        .proc2Dmem_addr     (proc2Dmem_addr),
        .proc2Dmem_data     (proc2Dmem_data),
        .mem2proc_response  (mem2proc_response),
        .mem2proc_data      (mem2proc_data),
        .mem2proc_tag       (mem2proc_tag),
        .proc2mem_command   (proc2mem_command),
        .proc2mem_addr      (proc2mem_addr),
        .proc2mem_data      (proc2mem_data),
        .Imem2proc_response (Imem2proc_response),
        .Dmem2proc_response (Dmem2proc_response),
        .Imem2proc_data     (Imem2proc_data),
        .Dmem2proc_data     (Dmem2proc_data),
        .Imem2proc_tag      (Imem2proc_tag),
        .Dmem2proc_tag      (Dmem2proc_tag),
        .arb_err            (arb_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    task automatic idle();
        proc2Imem_command = BUS_NONE;
        proc2Imem_addr    = '0;
        proc2Dmem_command = BUS_NONE;
        proc2Dmem_addr    = '0;
        proc2Dmem_data    = '0;
        mem2proc_response = '0;
        mem2proc_data     = '0;
        mem2proc_tag      = '0;
    endtask

    // Advance past the next rising edge; inputs are then driven and
    // outputs sampled well away from the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("reset_cmd",     64'(proc2mem_command), 64'(BUS_NONE));
        chk("reset_addr",    proc2mem_addr, 64'h0);
        chk("reset_data",    proc2mem_data, 64'h0);
        chk("reset_iresp",   64'(Imem2proc_response), 64'h0);
        chk("reset_dresp",   64'(Dmem2proc_response), 64'h0);
        chk("reset_itag",    64'(Imem2proc_tag), 64'h0);
        chk("reset_dtag",    64'(Dmem2proc_tag), 64'h0);
        chk("reset_arb_err", 64'(arb_err), 64'h0);

        // icache-only load, tag 3 returned 5 cycles later
        tick();
        proc2Imem_command = BUS_LOAD;
        proc2Imem_addr    = 64'h100;
        mem2proc_response = 4'd3;
        #1;
        chk("t1_cmd",   64'(proc2mem_command), 64'(BUS_LOAD));
        chk("t1_addr",  proc2mem_addr, 64'h100);
        chk("t1_data",  proc2mem_data, 64'h0);
        chk("t1_iresp", 64'(Imem2proc_response), 64'd3);
        chk("t1_dresp", 64'(Dmem2proc_response), 64'd0);
        tick();
        idle();
        tick();
        tick();
        tick();
        tick();
        mem2proc_tag  = 4'd3;
        mem2proc_data = 64'hDEAD;
        #1;
        chk("t1_itag",  64'(Imem2proc_tag), 64'd3);
        chk("t1_idata", Imem2proc_data, 64'hDEAD);
        chk("t1_dtag",  64'(Dmem2proc_tag), 64'd0);
        chk("t1_ddata", Dmem2proc_data, 64'h0);
        chk("t1_err",   64'(arb_err), 64'h0);
        tick();
        idle();

        // both request every cycle: D D D D I D
        proc2Imem_command = BUS_LOAD;
        proc2Imem_addr    = 64'h200;
        proc2Dmem_command = BUS_LOAD;
        proc2Dmem_addr    = 64'h300;
        mem2proc_response = 4'd9;
        #1;
        chk("t2_c1_addr", proc2mem_addr, 64'h300);
        chk("t2_c1_iresp", 64'(Imem2proc_response), 64'd0);
        tick();
        #1;
        chk("t2_c2_addr", proc2mem_addr, 64'h300);
        tick();
        #1;
        chk("t2_c3_addr", proc2mem_addr, 64'h300);
        tick();
        #1;
        chk("t2_c4_addr", proc2mem_addr, 64'h300);
        chk("t2_c4_dresp", 64'(Dmem2proc_response), 64'd9);
        tick();
        #1;
        chk("t2_c5_addr",  proc2mem_addr, 64'h200);
        chk("t2_c5_iresp", 64'(Imem2proc_response), 64'd9);
        chk("t2_c5_dresp", 64'(Dmem2proc_response), 64'd0);
        chk("t2_c5_data",  proc2mem_data, 64'h0);
        tick();
        #1;
        chk("t2_c6_addr",  proc2mem_addr, 64'h300);
        chk("t2_c6_dresp", 64'(Dmem2proc_response), 64'd9);
        tick();
        idle();
        // tag 9 was last allocated by dcache
        mem2proc_tag  = 4'd9;
        mem2proc_data = 64'h9999;
        #1;
        chk("t2_ret_dtag", 64'(Dmem2proc_tag), 64'd9);
        chk("t2_ret_itag", 64'(Imem2proc_tag), 64'd0);
        tick();
        idle();

        // icache tag 2, dcache tag 5, returned 5 then 2
        proc2Imem_command = BUS_LOAD;
        proc2Imem_addr    = 64'h500;
        mem2proc_response = 4'd2;
        tick();
        idle();
        proc2Dmem_command = BUS_LOAD;
        proc2Dmem_addr    = 64'h600;
        mem2proc_response = 4'd5;
        #1;
        chk("t4_dresp", 64'(Dmem2proc_response), 64'd5);
        tick();
        idle();
        mem2proc_tag  = 4'd5;
        mem2proc_data = 64'hAAAA;
        #1;
        chk("t4_r5_dtag",  64'(Dmem2proc_tag), 64'd5);
        chk("t4_r5_ddata", Dmem2proc_data, 64'hAAAA);
        chk("t4_r5_itag",  64'(Imem2proc_tag), 64'd0);
        chk("t4_r5_idata", Imem2proc_data, 64'h0);
        tick();
        idle();
        mem2proc_tag  = 4'd2;
        mem2proc_data = 64'hBBBB;
        #1;
        chk("t4_r2_itag",  64'(Imem2proc_tag), 64'd2);
        chk("t4_r2_idata", Imem2proc_data, 64'hBBBB);
        chk("t4_r2_dtag",  64'(Dmem2proc_tag), 64'd0);
        chk("t4_r2_ddata", Dmem2proc_data, 64'h0);
        tick();
        idle();

        // tag 4 returns to icache while dcache is reallocated tag 4
        proc2Imem_command = BUS_LOAD;
        proc2Imem_addr    = 64'h680;
        mem2proc_response = 4'd4;
        tick();
        idle();
        proc2Dmem_command = BUS_LOAD;
        proc2Dmem_addr    = 64'h700;
        mem2proc_response = 4'd4;
        mem2proc_tag      = 4'd4;
        mem2proc_data     = 64'hCCCC;
        #1;
        chk("t5_same_itag",  64'(Imem2proc_tag), 64'd4);
        chk("t5_same_idata", Imem2proc_data, 64'hCCCC);
        chk("t5_same_dtag",  64'(Dmem2proc_tag), 64'd0);
        chk("t5_same_dresp", 64'(Dmem2proc_response), 64'd4);
        tick();
        idle();
        mem2proc_tag  = 4'd4;
        mem2proc_data = 64'hDDDD;
        #1;
        chk("t5_new_dtag",  64'(Dmem2proc_tag), 64'd4);
        chk("t5_new_ddata", Dmem2proc_data, 64'hDDDD);
        chk("t5_new_itag",  64'(Imem2proc_tag), 64'd0);
        chk("t5_err",       64'(arb_err), 64'h0);
        tick();
        idle();

        // dcache store gets tag 7, then stray tag 7 returns
        proc2Dmem_command = BUS_STORE;
        proc2Dmem_addr    = 64'h400;
        proc2Dmem_data    = 64'h1234;
        mem2proc_response = 4'd7;
        #1;
        chk("t3_cmd",   64'(proc2mem_command), 64'(BUS_STORE));
        chk("t3_addr",  proc2mem_addr, 64'h400);
        chk("t3_data",  proc2mem_data, 64'h1234);
        chk("t3_dresp", 64'(Dmem2proc_response), 64'd7);
        tick();
        idle();
        mem2proc_tag  = 4'd7;
        mem2proc_data = 64'h5555;
        #1;
        chk("t3_itag",  64'(Imem2proc_tag), 64'd0);
        chk("t3_dtag",  64'(Dmem2proc_tag), 64'd0);
        chk("t3_ddata", Dmem2proc_data, 64'h0);
        chk("t3_err_before", 64'(arb_err), 64'h0);
        tick();
        idle();
        #1;
        chk("t3_err_after", 64'(arb_err), 64'h1);
        chk("t3_err_sticky_pre", 64'(arb_err), 64'h1);
        tick();
        #1;
        chk("t3_err_sticky", 64'(arb_err), 64'h1);

        // three tags outstanding, then reset clears the table
        proc2Imem_command = BUS_LOAD;
        proc2Imem_addr    = 64'h800;
        mem2proc_response = 4'd1;
        tick();
        idle();
        proc2Dmem_command = BUS_LOAD;
        proc2Dmem_addr    = 64'h900;
        mem2proc_response = 4'd6;
        tick();
        proc2Dmem_addr    = 64'hA00;
        mem2proc_response = 4'd10;
        tick();
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("t6_err_cleared", 64'(arb_err), 64'h0);
        mem2proc_tag  = 4'd6;
        mem2proc_data = 64'hEEEE;
        #1;
        chk("t6_dtag",  64'(Dmem2proc_tag), 64'd0);
        chk("t6_ddata", Dmem2proc_data, 64'h0);
        chk("t6_itag",  64'(Imem2proc_tag), 64'd0);
        tick();
        idle();
        #1;
        chk("t6_err_set", 64'(arb_err), 64'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
